// File: rtl/idex_hazard_ctrl.sv
// idex_hazard_ctrl
//
// Hazard controller for the ID/EX boundary. It watches the instruction in ID
// against the instruction currently held in the ID/EX register and against the
// multi-cycle multiply/divide unit that writes Hi/Lo. It produces:
//   - a stall for PC and IF/ID,
//   - a bubble (zeroed control) request for ID/EX,
//   - the sequencing of the mult/div unit, including a one-cycle Hi/Lo write
//     strobe.
//
// Parameters:
//   MUL_CYCLES  execute cycles for a multiply (1..64)
//   DIV_CYCLES  execute cycles for a divide   (1..64)
//
// Optional feature (compile-time macro HAZARD_FLOAT_EN):
//   defined     a load-use hazard also requires the source and destination to
//               be in the same register file (integer vs float).
//   undefined   register-file class is ignored, which is conservative.
//               id_float and ex_float stay on the port list.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   id_valid                    ID holds a valid instruction
//   id_rs, id_rt                ID source register numbers
//   id_uses_rs, id_uses_rt      the source is actually read
//   id_float                    ID sources are float registers
//   id_hilo_read                ID instruction reads Hi/Lo (mfhi/mflo)
//   id_md_start, id_md_div      ID instruction is mult/div; 1 = divide
//   ex_rwrite, ex_float         ID/EX RWrite / Float outputs
//   ex_wbsrc                    ID/EX WBsrc; 2'b01 means memory load
//   ex_dst                      ID/EX destination register
//   flush                       taken-branch flush from EX
//   stall_if                    hold PC and IF/ID (combinational)
//   bubble_idex                 load zero control into ID/EX (combinational)
//   md_busy                     mult/div in flight (registered)
//   md_done                     one-cycle Hi/Lo write strobe (registered)
//   md_cnt                      remaining execute cycles

module idex_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_float,
  input  logic       id_hilo_read,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic       ex_rwrite,
  input  logic       ex_float,
  input  logic [1:0] ex_wbsrc,
  input  logic [4:0] ex_dst,
  input  logic       flush,
  output logic       stall_if,
  output logic       bubble_idex,
  output logic       md_busy,
  output logic       md_done,
  output logic [5:0] md_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  localparam logic [1:0] WB_LOAD  = 2'b01;
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  mdState_t   state;
  mdState_t   stateNext;
  logic [5:0] cnt;
  logic [5:0] cntNext;

  logic floatMatch;
  logic srcHit;
  logic loadUse;
  logic mdHazard;
  logic accept;

`ifdef HAZARD_FLOAT_EN
  assign floatMatch = (id_float == ex_float);
`else
  // Register-file class is ignored: every numeric match is treated as a hit.
  logic unusedFloat;
  assign floatMatch  = 1'b1;
  assign unusedFloat = id_float ^ ex_float;
`endif

  // Load-use: the ID/EX instruction is a load whose result is read by the ID
  // instruction. r0 is never a real destination.
  assign srcHit = (id_uses_rs && (id_rs == ex_dst)) ||
                  (id_uses_rt && (id_rt == ex_dst));

  assign loadUse = id_valid && ex_rwrite && (ex_wbsrc == WB_LOAD) &&
                   (ex_dst != 5'd0) && srcHit && floatMatch;

  // Hi/Lo readers and new mult/div must wait until the unit is back in IDLE,
  // which is the cycle after the Hi/Lo write strobe.
  assign mdHazard = (state != IDLE) && id_valid && (id_hilo_read || id_md_start);

  // A mult/div that would itself be stalled or flushed must not start.
  assign accept = (state == IDLE) && id_valid && id_md_start && !loadUse && !flush;

  // Flush wins: the younger instruction is killed, so holding it is pointless.
  // During reset ID/EX is held as a bubble and the front end is free.
  assign stall_if    = rst_n && !flush && (loadUse || mdHazard);
  assign bubble_idex = !rst_n || flush || loadUse || mdHazard;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = BUSY;
          cntNext   = id_md_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt == 6'd0) begin
          stateNext = DONE;
        end else begin
          cntNext = cnt - 6'd1;
        end
      end
      DONE: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // md_busy/md_done are registered copies of the next state so they come
  // straight from flops rather than from a state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      md_busy <= (stateNext != IDLE);
      md_done <= (stateNext == DONE);
    end
  end

  assign md_cnt = cnt;

endmodule
